mult_seq_arb: RTL
=================

MULT_SEQ_ARB -- requirements
Module: mult_seq_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the operand width in bits; the product is 2*WIDTH bits wide.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req0, input, 1 bit: requester 0 asks for a multiply.
REQ-005 SHALL have ports a0 and b0, input, WIDTH bits each: requester 0 multiplicand and multiplier, unsigned.
REQ-006 SHALL have port req1, input, 1 bit: requester 1 asks for a multiply.
REQ-007 SHALL have ports a1 and b1, input, WIDTH bits each: requester 1 operands, unsigned.
REQ-008 SHALL have port gnt, output, 2 bits: one-hot grant; bit i means requester i's operands were captured.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when product is valid.
REQ-011 SHALL have port done_id, output, 1 bit: index of the requester owning the current product.
REQ-012 SHALL have port product, output, 2*WIDTH bits: registered unsigned result.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE, and SHALL enter no other state.
REQ-014 SHALL, in IDLE at a rising edge with any req high, select a winner, capture its operands, clear the accumulator and iteration count, record the owner, and enter CALC.
REQ-015 SHALL grant the only requester when exactly one of req0/req1 is high.
REQ-016 SHALL grant the requester holding the round-robin priority pointer when both are high; the pointer is 0 after reset.
REQ-017 SHALL, on leaving DONE, set the pointer to the requester that was not just served.
REQ-018 SHALL assert gnt[i] (registered) for exactly the first CALC cycle, with gnt == 2'b00 at all other times.
REQ-019 SHALL allow a requester to drop req and change operands after the cycle in which its gnt is high; operands SHALL NOT be resampled during CALC.
REQ-020 SHALL perform one shift-add iteration per CALC edge: if the multiplier LSB is 1, acc += multiplicand (2*WIDTH bits, no overflow possible); then multiplicand <<= 1, multiplier >>= 1, and count += 1.
REQ-021 SHALL leave CALC for DONE on the edge completing iteration WIDTH; there is no early termination for zero or small operands.
REQ-022 SHALL load product from the final accumulator on the DONE-entry edge, so done rises exactly WIDTH edges after gnt rises.
REQ-023 SHALL hold done high for exactly one cycle (the DONE state) and return to IDLE unconditionally.
REQ-024 SHALL ignore any request present in DONE until IDLE, giving one IDLE cycle between done and the next gnt under back-to-back requests.
REQ-025 SHALL hold product and done_id stable from DONE until the next DONE entry.
REQ-026 SHALL drive busy high in CALC and DONE and low in IDLE.

Reset
REQ-027 SHALL, while rst_n is low and regardless of clk, force state=IDLE, gnt=0, busy=0, done=0, done_id=0, product=0, pointer=0, accumulator=0, count=0.
REQ-028 SHALL, when rst_n is asserted mid-operation, abandon the operation with no done pulse; the first edge after release SHALL treat req as in IDLE.

Verification
REQ-029 Reset: rst_n low mid-cycle -> all outputs 0 immediately and held until release.
REQ-030 Max operands: req0 with a0=31, b0=31 -> gnt=01 for one cycle; 5 edges later done=1, product=961, done_id=0.
REQ-031 Simultaneous requests after reset: req0 (3,5) and req1 (7,9) both held -> gnt=01 first with product=15, then one IDLE cycle, then gnt=10 with product=63; a further simultaneous pair -> requester 0 first.
REQ-032 Zero operand: a1=0, b1=17 (WIDTH=5: b1=17 valid) -> product=0, done still 5 edges after gnt.
REQ-033 Abort: rst_n pulsed low during CALC iteration 3 -> no done, product=0; a following req0 (2,4) -> product=8 with normal latency.
REQ-034 Operand change after grant: a0/b0 changed in the CALC cycle after gnt -> product reflects the captured values only.

Source files
------------

// File: rtl/mult_seq_arb.sv
// rtl/mult_seq_arb.sv - two-requester arbitrated sequential shift-add multiplier
//
// Purpose:
//   Accepts multiply requests from two requesters. A round-robin pointer
//   breaks ties. The winner's operands are captured and multiplied unsigned
//   over WIDTH shift-add iterations. The result is then presented for one
//   cycle on done.
//
// Ports:
//   clk      - clock; all state changes on its rising edge
//   rst_n    - asynchronous active-low reset
//   req0     - requester 0 asks for a multiply
//   a0, b0   - requester 0 multiplicand / multiplier (unsigned, WIDTH bits)
//   req1     - requester 1 asks for a multiply
//   a1, b1   - requester 1 multiplicand / multiplier (unsigned, WIDTH bits)
//   gnt      - one-hot grant, high only during the first CALC cycle
//   busy     - high in CALC and DONE
//   done     - one-cycle pulse when product is valid
//   done_id  - requester that owns the current product
//   product  - registered unsigned result, 2*WIDTH bits

module mult_seq_arb #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  // The counter must be able to hold WIDTH itself, which it reaches on the
  // final iteration.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic             ptr;
  logic             owner;

  logic             win;
  logic [PW-1:0]    acc_next;
  logic             last_iter;

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ptr;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  // Accumulator value after the current iteration. The DONE-entry edge also
  // uses it, so product is loaded with the final sum and not one step behind.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign last_iter = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      product <= '0;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      acc     <= '0;
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state  <= CALC;
            gnt    <= win ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            owner  <= win;
            mcand  <= {{WIDTH{1'b0}}, (win ? a1 : a0)};
            mplier <= win ? b1 : b0;
            acc    <= '0;
            count  <= '0;
          end
        end

        CALC: begin
          // The grant covers only the first CALC cycle. Operands live in
          // mcand/mplier from here on, so the requester inputs are ignored.
          gnt    <= 2'b00;
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_iter) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= owner;
            product <= acc_next;
          end
        end

        DONE: begin
          // Requests seen here are deliberately ignored. Back-to-back
          // requests therefore always get one IDLE cycle before the next grant.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ptr   <= ~owner;
        end

        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
